// File: rtl/tsc_pkg.sv
// Shared definitions for the three-way sensor intersection: lamp codes driven
// by the controller and the loop debounce state encoding.
package tsc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [1:0] {
    ABSENT,
    RISE_PEND,
    PRESENT,
    FALL_PEND
  } deb_state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debounce FSM; rise/fall pulse on the
// edge at which the debounced presence changes.
module sync_debounce
  import tsc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  deb_state_t r_state;
  deb_state_t w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ABSENT;
      r_cnt   <= 8'd0;
    end else begin
      r_s1    <= din;
      r_s2    <= r_s1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // r_cnt holds the number of agreeing samples already taken in a PEND state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    rise         = 1'b0;
    fall         = 1'b0;
    unique case (r_state)
      ABSENT: begin
        if (r_s2) begin
          if (DEB_CYCLES == 1) begin
            w_state_next = PRESENT;
            rise         = 1'b1;
          end else begin
            w_state_next = RISE_PEND;
            w_cnt_next   = 8'd1;
          end
        end
      end
      RISE_PEND: begin
        if (!r_s2) begin
          w_state_next = ABSENT;
          w_cnt_next   = 8'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = PRESENT;
          w_cnt_next   = 8'd0;
          rise         = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      PRESENT: begin
        if (!r_s2) begin
          if (DEB_CYCLES == 1) begin
            w_state_next = ABSENT;
            fall         = 1'b1;
          end else begin
            w_state_next = FALL_PEND;
            w_cnt_next   = 8'd1;
          end
        end
      end
      FALL_PEND: begin
        if (r_s2) begin
          w_state_next = PRESENT;
          w_cnt_next   = 8'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = ABSENT;
          w_cnt_next   = 8'd0;
          fall         = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = ABSENT;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  assign dout = (r_state == PRESENT) || (r_state == FALL_PEND);

endmodule

// File: rtl/side_road_detector.sv
// Side-road loop front end: debounced presence, latched SENSOR call request,
// saturating vehicle count and stuck-loop fault with fail-safe recall.
module side_road_detector
  import tsc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned STUCK_CYCLES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       loop_raw,
  input  logic [2:0] SR,
  output logic       SENSOR,
  output logic       presence,
  output logic [7:0] vehicle_count,
  output logic       fault
);

  localparam logic [15:0] STUCK_MAX  = 16'(STUCK_CYCLES);
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);

  logic        w_presence;
  logic        w_rise;
  logic        w_fall;
  logic        w_green;
  logic        w_red;
  logic        r_sensor;
  logic [7:0]  r_count;
  logic [15:0] r_stuck;
  logic        r_fault;

  sync_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sync_debounce (
    .clk (clk),
    .rst (rst),
    .din (loop_raw),
    .dout(w_presence),
    .rise(w_rise),
    .fall(w_fall)
  );

  // Anything that is neither green nor yellow (including non-one-hot codes) is red.
  assign w_green = (SR == LAMP_GRN);
  assign w_red   = (SR == LAMP_RED) || !((SR == LAMP_GRN) || (SR == LAMP_YEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sensor <= 1'b0;
      r_count  <= 8'd0;
      r_stuck  <= 16'd0;
      r_fault  <= 1'b0;
    end else begin
      if (w_green) begin
        r_sensor <= 1'b0;
      end else if (r_fault) begin
        r_sensor <= 1'b1;
      end else if (w_red && w_presence) begin
        r_sensor <= 1'b1;
      end

      if (w_rise && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end

      if (w_fall) begin
        r_stuck <= 16'd0;
        r_fault <= 1'b0;
      end else if (w_presence && (r_stuck != STUCK_MAX)) begin
        r_stuck <= r_stuck + 16'd1;
        if (r_stuck == STUCK_LAST) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign SENSOR        = r_sensor;
  assign presence      = w_presence;
  assign vehicle_count = r_count;
  assign fault         = r_fault;

endmodule

// File: tb/tb_side_road_detector.sv
// Self-checking bench for side_road_detector: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_side_road_detector;

  localparam int DEB   = 4;
  localparam int STUCK = 20;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] BAD = 3'b011;

  // clock / reset
  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       loop_raw = 1'b0;
  logic [2:0] sr       = RED;
  logic       sensor;
  logic       presence;
  logic       fault;
  logic [7:0] vcount;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  side_road_detector #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .loop_raw     (loop_raw),
    .SR           (sr),
    .SENSOR       (sensor),
    .presence     (presence),
    .vehicle_count(vcount),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural model: presence flips once the last DEB synchronised samples
  // all disagree with it; fault = presence held for at least STUCK edges.
  bit m_s1, m_s2, m_pres, m_sensor, m_fault;
  int m_count = 0;
  int m_since = 0;
  bit hist[$];
  logic [10:0] exp_q[$];

  task automatic model_step();
    bit pres_n, sen_n, fault_n, all_opp, green, red;
    int cnt_n, since_n;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_pres = 0; m_sensor = 0; m_fault = 0;
      m_count = 0; m_since = 0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      pres_n = m_pres;
      if (hist.size() == DEB) begin
        all_opp = 1;
        foreach (hist[i]) if (hist[i] == m_pres) all_opp = 0;
        if (all_opp) pres_n = !m_pres;
      end
      cnt_n = (pres_n && !m_pres && m_count < 255) ? m_count + 1 : m_count;
      if (!pres_n) since_n = 0;
      else if (!m_pres) since_n = 0;
      else since_n = (m_since < STUCK) ? m_since + 1 : m_since;
      fault_n = pres_n && (since_n >= STUCK);
      green = (sr == GRN);
      red   = (sr != GRN) && (sr != YEL);
      if (green) sen_n = 0;
      else if (m_fault) sen_n = 1;
      else if (red && m_pres) sen_n = 1;
      else sen_n = m_sensor;
      m_s2 = m_s1; m_s1 = loop_raw;
      m_pres = pres_n; m_count = cnt_n; m_since = since_n;
      m_fault = fault_n; m_sensor = sen_n;
    end
    if (chk_on) exp_q.push_back({m_sensor, m_pres, m_fault, 8'(m_count)});
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: one compare per cycle against the model
  always @(negedge clk) begin
    logic [10:0] e;
    if (chk_on) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model_sensor", 16'(sensor), 16'(e[10]));
        check("model_presence", 16'(presence), 16'(e[9]));
        check("model_fault", 16'(fault), 16'(e[8]));
        check("model_count", 16'(vcount), 16'(e[7:0]));
      end
    end
  end

  // driver: called at a falling edge, applies inputs across one rising edge
  task automatic cyc(input logic l, input logic [2:0] s, input logic r);
    loop_raw = l; sr = s; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int p, f;
    bit found, last_fault;
    logic l;
    logic [2:0] s;
    int hold_l, hold_s;

    cyc(0, RED, 1);
    cyc(0, RED, 1);
    chk_on = 1;
    check("reset_sensor", 16'(sensor), 0);
    check("reset_presence", 16'(presence), 0);
    check("reset_fault", 16'(fault), 0);
    check("reset_count", 16'(vcount), 0);

    // arrival under red: presence after edge 5, SENSOR after edge 6
    for (int e = 0; e <= 5; e++) begin
      cyc(1, RED, 0);
      if (e == 4) check("arrive_pres_edge4", 16'(presence), 0);
    end
    check("arrive_pres_edge5", 16'(presence), 1);
    check("arrive_count", 16'(vcount), 1);
    check("arrive_sensor_edge5", 16'(sensor), 0);
    cyc(1, RED, 0);
    check("arrive_sensor_edge6", 16'(sensor), 1);

    // departure: presence drops after 6 edges, request stays latched
    repeat (5) cyc(0, RED, 0);
    check("depart_pres_edge4", 16'(presence), 1);
    cyc(0, RED, 0);
    check("depart_pres_edge5", 16'(presence), 0);
    check("depart_sensor_latched", 16'(sensor), 1);

    // green clears; arrival during green counts but does not request
    cyc(0, GRN, 0);
    check("green_clears", 16'(sensor), 0);
    repeat (6) cyc(1, GRN, 0);
    check("green_arrival_pres", 16'(presence), 1);
    check("green_arrival_count", 16'(vcount), 2);
    check("green_arrival_sensor", 16'(sensor), 0);
    cyc(1, RED, 0);
    check("red_return_sensor", 16'(sensor), 1);

    // glitch of 3 cycles is rejected
    cyc(0, RED, 1);
    repeat (3) cyc(1, RED, 0);
    repeat (8) cyc(0, RED, 0);
    check("glitch_pres", 16'(presence), 0);
    check("glitch_sensor", 16'(sensor), 0);
    check("glitch_count", 16'(vcount), 0);

    // stuck loop with lamp cycling
    cyc(0, RED, 1);
    p = -1; f = -1;
    for (int e = 0; e < 30; e++) begin
      cyc(1, (e % 6 < 3) ? RED : ((e % 6 < 5) ? GRN : YEL), 0);
      if (presence && p < 0) p = e;
      if (fault && f < 0) f = e;
    end
    check("fault_latency", 16'(f - p), 16'(STUCK));
    found = 0;
    last_fault = fault;
    for (int e = 0; e < 12 && !found; e++) begin
      cyc(0, RED, 0);
      if (!presence) begin
        found = 1;
        check("fault_clears_on_fall", 16'(fault), 0);
        check("fault_held_before_fall", 16'(last_fault), 1);
      end else begin
        last_fault = fault;
      end
    end
    check("fall_seen_in_budget", 16'(found), 1);

    // 260 clean arrivals saturate the count
    cyc(0, RED, 1);
    for (int a = 0; a < 260; a++) begin
      repeat (6) cyc(1, RED, 0);
      repeat (6) cyc(0, RED, 0);
    end
    check("count_saturates", 16'(vcount), 255);

    // invalid lamp code treated as red; reset wins on the same edge
    cyc(0, RED, 1);
    repeat (7) cyc(1, GRN, 0);
    check("bad_setup_pres", 16'(presence), 1);
    check("bad_setup_sensor", 16'(sensor), 0);
    cyc(1, BAD, 1);
    check("rst_wins_sensor", 16'(sensor), 0);
    check("rst_wins_count", 16'(vcount), 0);
    repeat (7) cyc(1, GRN, 0);
    cyc(1, BAD, 0);
    check("bad_code_is_red", 16'(sensor), 1);
    cyc(1, BAD, 1);
    check("rst_sensor", 16'(sensor), 0);
    check("rst_presence", 16'(presence), 0);
    check("rst_count", 16'(vcount), 0);
    check("rst_fault", 16'(fault), 0);

    // randomized traffic
    hold_l = 0; hold_s = 0; l = 0; s = RED;
    for (int i = 0; i < 3000; i++) begin
      if (hold_l == 0) begin
        l = 1'($urandom_range(0, 1));
        hold_l = (l && $urandom_range(0, 5) == 0) ? $urandom_range(25, 40) : $urandom_range(1, 10);
      end
      hold_l--;
      if (hold_s == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2: s = RED;
          3:       s = YEL;
          4, 5:    s = GRN;
          6:       s = BAD;
          default: s = 3'($urandom_range(0, 7));
        endcase
        hold_s = $urandom_range(1, 15);
      end
      hold_s--;
      cyc(l, s, ($urandom_range(0, 399) == 0));
    end

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
